instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 132 +++++++++++++
 tb/tb_instr_fetch.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns PC, 3-cycle best-case req->resp->hold loop, holds instr until instr_ready; req held until imem_req_ready.
// Optional IFU_MISALIGN_CHECK_EN adds a sticky FAULT state and fetch_fault output for a misaligned next_pc.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic        func7,
  input  logic [31:0] next_pc,
  output logic [31:0] fetch_cnt
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

`ifdef IFU_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [31:0] r_instr_pc;
  logic [31:0] w_instr_pc_nxt;
  logic [31:0] r_fetch_cnt;
  logic [31:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_cnt_nxt      = r_fetch_cnt;
    case (r_state)
      S_REQ: begin
        if (imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          w_instr_nxt    = imem_resp_data;
          w_instr_pc_nxt = r_pc;
          w_state_nxt    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          w_cnt_nxt = r_fetch_cnt + 32'd1;
`ifdef IFU_MISALIGN_CHECK_EN
          // PC still takes the bad target so it is visible for debug in FAULT.
          w_pc_nxt    = next_pc;
          w_state_nxt = (next_pc[1:0] != 2'b00) ? S_FAULT : S_REQ;
`else
          w_pc_nxt    = next_pc & ~32'h0000_0003;
          w_state_nxt = S_REQ;
`endif
        end
      end
      default: begin
        // FAULT is sticky until reset.
        w_state_nxt = r_state;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_instr     <= NOP;
      r_instr_pc  <= RESET_PC;
      r_fetch_cnt <= 32'd0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_instr     <= w_instr_nxt;
      r_instr_pc  <= w_instr_pc_nxt;
      r_fetch_cnt <= w_cnt_nxt;
    end
  end

  // rst_n gating keeps the request quiet during reset yet live in the first cycle after release.
  assign imem_req_valid = rst_n & (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign instr_valid    = (r_state == S_HOLD);
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign opcode         = r_instr[6:0];
  assign func3          = r_instr[14:12];
  assign func7          = r_instr[30];
  assign fetch_cnt      = r_fetch_cnt;

`ifdef IFU_MISALIGN_CHECK_EN
  assign fetch_fault = (r_state == S_FAULT);
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: scripted memory/consumer with a scoreboard of expected {word, pc} per accepted request.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7;
  logic [31:0] next_pc;
  logic [31:0] fetch_cnt;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .func3          (func3),
    .func7          (func7),
    .next_pc        (next_pc),
    .fetch_cnt      (fetch_cnt)
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h8000_0100) return 32'h0000_0513;
    return (addr * 32'h9E37_79B1) ^ 32'h4000_5033;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    instr_ready     = 1'b0;
    next_pc         = 32'h0;
    @(negedge clk);
    @(negedge clk);
    sb.delete();
    exp_pc  = RST_PC;
    exp_cnt = 32'd0;
  endtask

  // One full transaction: request stalled rdy_dly cycles, response after lat cycles, held hold cycles, consumed with npc.
  task automatic fetch_one(input int rdy_dly, input int lat, input int hold, input logic [31:0] npc);
    int   n;
    exp_t e;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (imem_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL req_wait: imem_req_valid=%b want 1", imem_req_valid);
      return;
    end
    total++;
    if (imem_req_addr !== exp_pc) begin
      bad++;
      $display("FAIL req_addr: got %h want %h", imem_req_addr, exp_pc);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
        bad++;
        $display("FAIL req_stall: valid=%b addr=%h want 1 %h", imem_req_valid, imem_req_addr, exp_pc);
      end
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    sb.push_back('{word: mem_word(exp_pc), pc: exp_pc});
    total++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL wait_entry: req_valid=%b instr_valid=%b want 0 0", imem_req_valid, instr_valid);
    end
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL wait_idle: instr_valid=%b want 0", instr_valid);
      end
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = mem_word(exp_pc);
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'hDEAD_BEEF;
    total++;
    if (instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL instr_valid_rise: got %b want 1", instr_valid);
    end
    e = sb.pop_front();
    total++;
    if (instr !== e.word || instr_pc !== e.pc) begin
      bad++;
      $display("FAIL instr_data: instr=%h pc=%h want %h %h", instr, instr_pc, e.word, e.pc);
    end
    total++;
    if (opcode !== e.word[6:0] || func3 !== e.word[14:12] || func7 !== e.word[30]) begin
      bad++;
      $display("FAIL fields: op=%h f3=%h f7=%b want %h %h %b", opcode, func3, func7,
               e.word[6:0], e.word[14:12], e.word[30]);
    end
    for (int i = 0; i < hold; i++) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = ~e.word;
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1 || instr !== e.word || instr_pc !== e.pc ||
          fetch_cnt !== exp_cnt || imem_req_valid !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable: v=%b instr=%h pc=%h cnt=%h req=%b want 1 %h %h %h 0",
                 instr_valid, instr, instr_pc, fetch_cnt, imem_req_valid, e.word, e.pc, exp_cnt);
      end
    end
    imem_resp_valid = 1'b0;
    next_pc         = npc;
    instr_ready     = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    next_pc     = 32'h0;
    exp_cnt     = exp_cnt + 32'd1;
    exp_pc      = {npc[31:2], 2'b00};
    total++;
    if (fetch_cnt !== exp_cnt || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL consume: cnt=%h instr_valid=%b want %h 0", fetch_cnt, instr_valid, exp_cnt);
    end
`ifdef IFU_MISALIGN_CHECK_EN
    if (npc[1:0] != 2'b00) begin
      total++;
      if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0) begin
        bad++;
        $display("FAIL fault_entry: fault=%b req=%b want 1 0", fetch_fault, imem_req_valid);
      end
      return;
    end
    total++;
    if (fetch_fault !== 1'b0) begin
      bad++;
      $display("FAIL fault_clear: fault=%b want 0", fetch_fault);
    end
`endif
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
      bad++;
      $display("FAIL next_req: valid=%b addr=%h want 1 %h", imem_req_valid, imem_req_addr, exp_pc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valids: req=%b instr=%b want 0 0", imem_req_valid, instr_valid);
    end
    total++;
    if (instr !== 32'h0000_0013 || instr_pc !== RST_PC || imem_req_addr !== RST_PC || fetch_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_regs: instr=%h pc=%h addr=%h cnt=%h want 00000013 %h %h 0",
               instr, instr_pc, imem_req_addr, fetch_cnt, RST_PC, RST_PC);
    end
`ifdef IFU_MISALIGN_CHECK_EN
    total++;
    if (fetch_fault !== 1'b0) begin
      bad++;
      $display("FAIL reset_fault: got %b want 0", fetch_fault);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    fetch_one(0, 1, 0, 32'h8000_0010);
  endtask

  task automatic test_req_stall();
    fetch_one(5, 2, 0, 32'h8000_0100);
  endtask

  task automatic test_hold();
    fetch_one(0, 3, 4, 32'h8000_0040);
    total++;
    if (opcode !== 7'h13 || func3 !== 3'd0 || func7 !== 1'b0 || instr !== 32'h0000_0513) begin
      bad++;
      $display("FAIL hold_fields_513: instr=%h op=%h f3=%h f7=%b want 00000513 13 0 0",
               instr, opcode, func3, func7);
    end
  endtask

  task automatic test_next_pc();
    fetch_one(0, 1, 0, 32'h8000_0044);
  endtask

  task automatic test_cnt_wrap();
    dut.r_fetch_cnt = 32'hFFFF_FFFE;
    exp_cnt         = 32'hFFFF_FFFE;
    fetch_one(0, 1, 1, 32'h8000_0048);
    fetch_one(0, 2, 0, 32'h8000_004C);
    total++;
    if (fetch_cnt !== 32'd0) begin
      bad++;
      $display("FAIL cnt_wrap: got %h want 00000000", fetch_cnt);
    end
  endtask

  task automatic test_reset_in_wait();
    int n;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst_n          = 1'b0;
    #1;
    total++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: req=%b instr_valid=%b want 0 0", imem_req_valid, instr_valid);
    end
    @(negedge clk);
    rst_n           = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1234_5678;
    sb.delete();
    exp_pc  = RST_PC;
    exp_cnt = 32'd0;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    total++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || fetch_cnt !== 32'd0) begin
      bad++;
      $display("FAIL stale_resp: iv=%b req=%b addr=%h cnt=%h want 0 1 %h 0",
               instr_valid, imem_req_valid, imem_req_addr, fetch_cnt, RST_PC);
    end
    fetch_one(0, 1, 0, 32'h8000_0040);
  endtask

  task automatic test_misalign();
    fetch_one(0, 1, 2, 32'h8000_0042);
`ifdef IFU_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      @(negedge clk);
      total++;
      if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL fault_sticky: fault=%b req=%b iv=%b want 1 0 0", fetch_fault, imem_req_valid, instr_valid);
      end
    end
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    do_reset();
    rst_n = 1'b1;
    total++;
    if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      bad++;
      $display("FAIL fault_reset: fault=%b req=%b addr=%h want 0 1 %h", fetch_fault, imem_req_valid, imem_req_addr, RST_PC);
    end
`else
    fetch_one(0, 1, 0, 32'h8000_0000);
`endif
  endtask

  initial begin
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    instr_ready     = 1'b0;
    next_pc         = 32'h0;
    exp_pc          = RST_PC;
    exp_cnt         = 32'd0;
    test_reset();
    test_first_fetch();
    test_req_stall();
    test_hold();
    test_next_pc();
    test_cnt_wrap();
    test_reset_in_wait();
    test_misalign();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
